// File: rtl/fwd_pkg.sv
// Shared types and select codes for the EX-stage forwarding and hazard control.
package fwd_pkg;

   localparam int FWD_AW = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic [FWD_AW-1:0] rd;
      logic              rw;
      logic              mr;
      logic [FWD_AW-1:0] rs1;
      logic [FWD_AW-1:0] rs2;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '{
      rd:  '0,
      rw:  1'b0,
      mr:  1'b0,
      rs1: '0,
      rs2: '0
   };

endpackage

// File: rtl/fwd_operand_sel.sv
// Forwarding select for one EX operand: newest producer (EX/MEM) wins over MEM/WB.
module fwd_operand_sel
   import fwd_pkg::*;
#(
   parameter int REG_AW = FWD_AW
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_rw,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_rw,
   output logic [1:0]        sel
);

   logic mem_hit;
   logic wb_hit;

   always_comb begin
      mem_hit = mem_rw && (mem_rd != '0) && (mem_rd == src);
      wb_hit  = wb_rw && (wb_rd != '0) && (wb_rd == src);
      sel     = FWD_RF;
      if (mem_hit) begin
         sel = FWD_EXMEM;
      end else if (wb_hit) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Tracks rd/write-enable through EX, MEM and WB; drives operand forwarding
// selects, the load-use stall and a saturating stall counter.
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int REG_AW = FWD_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   stage_t            ex_q;
   stage_t            ex_d;
   logic [REG_AW-1:0] mem_rd_q;
   logic [REG_AW-1:0] mem_rd_d;
   logic              mem_rw_q;
   logic              mem_rw_d;
   logic [REG_AW-1:0] wb_rd_q;
   logic [REG_AW-1:0] wb_rd_d;
   logic              wb_rw_q;
   logic              wb_rw_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   logic hit_rs1;
   logic hit_rs2;
   logic stall_w;

   // Load in EX whose result the ID instruction needs; flush overrides.
   always_comb begin
      hit_rs1 = (ex_q.rd == id_rs1);
      hit_rs2 = id_uses_rs2 && (ex_q.rd == id_rs2);
      stall_w = id_valid && !flush && ex_q.mr &&
                (ex_q.rd != '0) && (hit_rs1 || hit_rs2);
   end

   always_comb begin
      ex_d = STAGE_BUBBLE;
      if (id_valid && !stall_w && !flush) begin
         ex_d.rd  = id_rd;
         ex_d.rw  = id_reg_write;
         ex_d.mr  = id_mem_read;
         ex_d.rs1 = id_rs1;
         ex_d.rs2 = id_rs2;
      end
      mem_rd_d = ex_q.rd;
      mem_rw_d = ex_q.rw;
      wb_rd_d  = mem_rd_q;
      wb_rw_d  = mem_rw_q;
      cnt_d    = cnt_q;
      if (stall_w && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q     <= STAGE_BUBBLE;
         mem_rd_q <= '0;
         mem_rw_q <= 1'b0;
         wb_rd_q  <= '0;
         wb_rw_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         ex_q     <= ex_d;
         mem_rd_q <= mem_rd_d;
         mem_rw_q <= mem_rw_d;
         wb_rd_q  <= wb_rd_d;
         wb_rw_q  <= wb_rw_d;
         cnt_q    <= cnt_d;
      end
   end

   fwd_operand_sel #(
      .REG_AW (REG_AW)
   ) u_sel_a (
      .src    (ex_q.rs1),
      .mem_rd (mem_rd_q),
      .mem_rw (mem_rw_q),
      .wb_rd  (wb_rd_q),
      .wb_rw  (wb_rw_q),
      .sel    (fwd_a_sel)
   );

   fwd_operand_sel #(
      .REG_AW (REG_AW)
   ) u_sel_b (
      .src    (ex_q.rs2),
      .mem_rd (mem_rd_q),
      .mem_rw (mem_rw_q),
      .wb_rd  (wb_rd_q),
      .wb_rw  (wb_rw_q),
      .sel    (fwd_b_sel)
   );

   assign stall       = stall_w;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized bench for fwd_hazard_ctrl against an instruction-history model.
module tb_fwd_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid;
   logic [AW-1:0] id_rs1;
   logic [AW-1:0] id_rs2;
   logic          id_uses_rs2;
   logic [AW-1:0] id_rd;
   logic          id_reg_write;
   logic          id_mem_read;
   logic          flush;
   logic [1:0]    fwd_a_sel;
   logic [1:0]    fwd_b_sel;
   logic          stall;
   logic [CW-1:0] stall_count;

   fwd_hazard_ctrl #(
      .REG_AW (AW),
      .CNT_W  (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs2  (id_uses_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall        (stall),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v;
      bit rw;
      bit mr;
      bit u2;
      int rd;
      int rs1;
      int rs2;
   } ins_t;

   // hist[0] is the instruction in EX, hist[1] one cycle older, hist[2] two.
   ins_t hist[3];
   ins_t nop_i;
   int   exp_cnt;
   int   n_chk;
   int   n_fail;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ins_t mk(bit rw, bit mr, bit u2, int rd, int rs1, int rs2);
      ins_t i;
      i.v = 1'b1; i.rw = rw; i.mr = mr; i.u2 = u2;
      i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
      return i;
   endfunction

   // Newest older instruction that writes a nonzero src supplies the value.
   function automatic int fwd_exp(int src);
      if (src == 0) return 0;
      for (int age = 1; age <= 2; age++) begin
         if (hist[age].v && hist[age].rw && hist[age].rd == src) return age;
      end
      return 0;
   endfunction

   function automatic bit stall_exp(ins_t id, bit fl);
      if (!id.v || fl) return 1'b0;
      if (!hist[0].v || !hist[0].mr || hist[0].rd == 0) return 1'b0;
      return (hist[0].rd == id.rs1) || (id.u2 && hist[0].rd == id.rs2);
   endfunction

   task automatic drive(input ins_t id, input bit fl);
      id_valid     = id.v;
      id_rs1       = AW'(id.rs1);
      id_rs2       = AW'(id.rs2);
      id_uses_rs2  = id.u2;
      id_rd        = AW'(id.rd);
      id_reg_write = id.rw;
      id_mem_read  = id.mr;
      flush        = fl;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) hist[i] = nop_i;
      exp_cnt = 0;
   endtask

   task automatic step(input ins_t id, input bit fl, output bit st);
      @(negedge clk);
      drive(id, fl);
      #1;
      st = stall_exp(id, fl);
      check("fwd_a", 32'(fwd_a_sel), 32'(fwd_exp(hist[0].rs1)));
      check("fwd_b", 32'(fwd_b_sel), 32'(fwd_exp(hist[0].rs2)));
      check("stall", 32'(stall), 32'(st));
      check("stall_count", 32'(stall_count), 32'(exp_cnt));
      @(posedge clk);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (id.v && !st && !fl) ? id : nop_i;
      if (st && exp_cnt < CMAX) exp_cnt++;
   endtask

   // Re-present a stalled instruction until it is accepted, with a bound.
   task automatic issue(input ins_t id, input bit fl);
      bit st;
      int k;
      k = 0;
      do begin
         step(id, fl, st);
         k++;
      end while (st && k < 4);
      check("stall_bound", 32'(st), 32'd0);
   endtask

   initial begin
      ins_t cur;
      bit   st;
      bit   fl;
      nop_i = '{default: 0};
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      drive(nop_i, 1'b0);
      model_reset();
      #1;
      check("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
      check("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_count", 32'(stall_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // EX/MEM forward: add x5 ; sub x6,x5,x1
      issue(mk(1, 0, 1, 5, 1, 2), 0);
      issue(mk(1, 0, 1, 6, 5, 1), 0);
      issue(nop_i, 0);
      // MEM/WB forward: addi x3 ; nop ; and x4,x3,x3
      issue(mk(1, 0, 0, 3, 1, 0), 0);
      issue(nop_i, 0);
      issue(mk(1, 0, 1, 4, 3, 3), 0);
      issue(nop_i, 0);
      // Back-to-back writers of x3, reader takes the newest
      issue(mk(1, 0, 0, 3, 1, 0), 0);
      issue(mk(1, 0, 0, 3, 3, 0), 0);
      issue(mk(1, 0, 1, 4, 3, 3), 0);
      issue(nop_i, 0);
      // Load-use: lw x7 ; add x8,x7,x2
      issue(mk(1, 1, 0, 7, 1, 0), 0);
      issue(mk(1, 0, 1, 8, 7, 2), 0);
      issue(nop_i, 0);
      // x0 writer, then reader of x0
      issue(mk(1, 0, 0, 0, 1, 0), 0);
      issue(mk(1, 0, 1, 2, 0, 0), 0);
      issue(nop_i, 0);
      // Store (no write) with matching rd
      issue(mk(0, 0, 1, 5, 1, 2), 0);
      issue(mk(1, 0, 1, 6, 5, 5), 0);
      issue(nop_i, 0);
      // Flush beats load-use
      issue(mk(1, 1, 0, 9, 1, 0), 0);
      issue(mk(1, 0, 1, 1, 9, 9), 1);
      issue(nop_i, 0);

      // Random traffic over a small register set to force frequent hazards
      cur = nop_i;
      st = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (!st) begin
            cur.v  = ($urandom_range(0, 9) != 0);
            cur.rw = ($urandom_range(0, 3) != 0);
            cur.mr = ($urandom_range(0, 2) == 0);
            cur.u2 = $urandom_range(0, 1);
            cur.rd  = $urandom_range(0, 3);
            cur.rs1 = $urandom_range(0, 3);
            cur.rs2 = $urandom_range(0, 3);
            if (!cur.v) cur = nop_i;
         end
         fl = ($urandom_range(0, 9) == 0);
         step(cur, fl, st);
      end
      check("count_saturated", 32'(stall_count), 32'(CMAX));

      // Asynchronous reset while a load-use stall is active
      issue(nop_i, 0);
      issue(mk(1, 1, 0, 7, 1, 0), 0);
      @(negedge clk);
      cur = mk(1, 0, 1, 8, 7, 2);
      drive(cur, 1'b0);
      #1;
      check("pre_rst_stall", 32'(stall), 32'(stall_exp(cur, 1'b0)));
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_stall", 32'(stall), 32'd0);
      check("mid_rst_fwd_a", 32'(fwd_a_sel), 32'd0);
      check("mid_rst_fwd_b", 32'(fwd_b_sel), 32'd0);
      check("mid_rst_count", 32'(stall_count), 32'(exp_cnt));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Producer side of the EX-stage operand-select muxes in the pipelined core. The block tracks destination-register and write-enable information through the ID/EX, EX/MEM and MEM/WB stages. From that state it generates the 2-bit forwarding selects for ALU operands A and B, the load-use stall request, and a saturating stall counter. It sits beside the pipeline registers and drives the sel inputs of the operand N-bit muxes.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID-stage slot holds a real instruction
id_rs1  in  REG_AW  ID source register 1
id_rs2  in  REG_AW  ID source register 2
id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types)
id_rd  in  REG_AW  ID destination register
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
flush  in  1  branch/jump taken; squash the instruction leaving ID
fwd_a_sel  out  2  EX operand A select
fwd_b_sel  out  2  EX operand B select
stall  out  1  hold PC and IF/ID; insert bubble into EX
stall_count  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Reset: one clock and async active-low reset rst_n. Reset clears all tracked stage state (valid/rw/mr=0, addresses=0). Consequently fwd_a_sel=fwd_b_sel=00, stall=0, stall_count=0 immediately and asynchronously.
- Tracked state:
  - EX: ex_rs1, ex_rs2, ex_rd, ex_rw, ex_mr
  - MEM: mem_rd, mem_rw
  - WB: wb_rd, wb_rw
- Each rising edge:
  - MEM<=EX and WB<=MEM, unconditionally.
  - EX<=ID fields when id_valid and not stall and not flush.
  - Otherwise EX<=bubble: rw=0, mr=0, addresses=0.
- Select codes: 00 register file, 01 EX/MEM result, 10 MEM/WB result. Code 11 is never driven.
- fwd_a_sel is combinational from registered state:
  - 01 if mem_rw and mem_rd!=0 and mem_rd==ex_rs1
  - else 10 if wb_rw and wb_rd!=0 and wb_rd==ex_rs1
  - else 00
  - EX/MEM has priority (newest value).
- fwd_b_sel: same rules against ex_rs2.
- Selects apply to the instruction currently in EX, in the same cycle; zero added latency.
- x0 is never forwarded regardless of rw.
- stall (combinational) = id_valid & ~flush & ex_mr & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- Load-use produces exactly one stall cycle: the bubble clears ex_mr, and the load then forwards from MEM/WB (10).
- Flush and stall together: flush wins, stall=0, and a bubble enters EX.
- WB-to-ID same-cycle hazard is not handled here; the register file writes in the first half-cycle.
- stall_count increments on each edge where stall=1 and holds at all-ones (no wrap).
- Reset mid-stall: stall drops immediately and the counter clears.

Decomposition:
- Package fwd_pkg holds:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10
  - the stage-record typedef (rd, rw, mr, rs1, rs2)
  - the bubble constant
- One sub-module, fwd_operand_sel: pure priority compare of one source register against the MEM/WB records. It is instantiated twice (A, B).
- Stage tracking, stall logic and counter live in the top.

Test Plan:
1. EX/MEM forward: add x5 issued, then sub x6,x5,x1 next cycle → when sub is in EX, fwd_a_sel=01, fwd_b_sel=00.
2. MEM/WB forward with priority:
   - Case (a): addi x3; nop; and x4,x3,x3 → and in EX gives fwd_a_sel=fwd_b_sel=10.
   - Case (b): addi x3 followed by addi x3 back-to-back, then a reader → reader gets 01, not 10.
3. Load-use: lw x7 then add x8,x7,x2 → stall=1 for exactly one cycle, stall_count 0→1; add then sees fwd_a_sel=10.
4. x0 and no-write filtering:
   - Case (a): writer rd=0 followed by reader of x0 → selects 00.
   - Case (b): sw (id_reg_write=0) targeting rs match → selects 00.
5. Flush priority: lw x9 in EX, ID holds add x1,x9,x9 with flush=1 → stall=0; next cycle EX is a bubble and stall_count is unchanged.
6. Reset/saturation:
   - Case (a): with CNT_W=4, force 20 load-use stalls → stall_count holds at 15.
   - Case (b): assert rst_n=0 mid-stall → stall, both selects and stall_count go to 0 without waiting for a clock edge.
